sl_transmitter: RTL and testbench

Serial-line (SL) transmitter: it is the counterpart of `SlReceiver` and drives the same two-wire line. Each data bit is a low pulse on the zeroes line (bit = 0) or on the ones line (bit = 1). The word is sent LSB first, followed by a two-line parity slot and a both-low stop marker. The CPU-side port is a config register plus a one-deep word buffer with a valid/ready handshake. The block is used as the line source in loopback tests against `SlReceiver`.

---
 rtl/sl_transmitter.sv | 127 ++++++++++++
 tb/tb_sl_transmitter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sl_transmitter.sv
// sl_transmitter: two-wire serial-line transmitter with config register and one-deep word buffer.
// Length field 0 encodes N = 32; define SL_TX_PARITY_INJECT_EN to enable config bit [8] parity inversion.
module sl_transmitter (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_enable,
  input  logic [15:0] wr_config_w,
  output logic [15:0] r_config_w,
  input  logic [31:0] tx_data_w,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        serial_line_zeroes_o,
  output logic        serial_line_ones_o,
  output logic [15:0] status_w,
  output logic        frame_done
);
  typedef enum logic [3:0] {IDLE, BIT_PRE, BIT_LOW, BIT_POST, PAR_GAP, PAR, PAR_POST, STOP, STOP_POST} state_t;
  state_t st_q, st_d;
  logic [8:0] cfg_q, cfg_d, shd_q, shd_d, cfg_wr;
  logic [31:0] buf_q, buf_d, sh_q, sh_d;
  logic [6:0] cnt_q, cnt_d, h;
  logic [5:0] bits_q, bits_d;
  logic par_q, par_d, full_q, full_d, rdy_q, rdy_d, err_q, err_d;
  logic busy_q, busy_d, done_q, done_d, sl0_q, sl0_d, sl1_q, sl1_d;
  logic wr_ok, last1, last2, start, inj, unused_bits;
  function automatic logic [5:0] n_of(input logic [8:0] c);
    return c[5:1] == 5'd0 ? 6'd32 : {1'b0, c[5:1]};
  endfunction
`ifdef SL_TX_PARITY_INJECT_EN
  assign cfg_wr = wr_config_w[8:0];
`else
  assign cfg_wr = {1'b0, wr_config_w[7:0]};
`endif
  assign unused_bits = ^wr_config_w[15:8];
  assign wr_ok = !wr_config_w[1] && (wr_config_w[5:1] == 5'd0 || wr_config_w[5:1] >= 5'd8);
  assign h = 7'd4 << shd_q[7:6];
  assign last1 = cnt_q == h - 7'd1;
  assign last2 = cnt_q == (h << 1) - 7'd1;
  assign r_config_w = {7'b0, cfg_q};
  assign tx_ready = rdy_q;
  assign serial_line_zeroes_o = sl0_q;
  assign serial_line_ones_o = sl1_q;
  assign status_w = {13'b0, err_q, full_q, busy_q};
  assign frame_done = done_q;
  always_comb begin
    cfg_d = wr_enable && wr_ok ? cfg_wr : cfg_q;
    err_d = wr_enable ? !wr_ok : err_q;
    buf_d = tx_valid && rdy_q ? tx_data_w : buf_q;
    full_d = full_q || (tx_valid && rdy_q);
    st_d = st_q;
    sh_d = sh_q;
    bits_d = bits_q;
    shd_d = shd_q;
    par_d = par_q;
    start = 1'b0;
    case (st_q)
      IDLE:      start = full_q;
      BIT_PRE:   if (last1) st_d = BIT_LOW;
      BIT_LOW:   if (last2) st_d = BIT_POST;
      BIT_POST:  if (last1) begin
        sh_d = sh_q >> 1;
        bits_d = bits_q + 6'd1;
        st_d = bits_d == n_of(shd_q) ? PAR_GAP : BIT_PRE;
      end
      PAR_GAP:   if (last1) st_d = PAR;
      PAR:       if (last2) st_d = PAR_POST;
      PAR_POST:  if (last2) st_d = STOP;
      STOP:      if (last2) st_d = STOP_POST;
      STOP_POST: if (last1) begin
        start = full_q;
        st_d = IDLE;
      end
      default:   st_d = IDLE;
    endcase
    // Frame start picks up a config written in this same cycle.
    if (start) begin
      st_d = BIT_PRE;
      shd_d = cfg_d;
      sh_d = buf_q;
      bits_d = '0;
      par_d = ^(buf_q & ~(32'hFFFF_FFFF << n_of(cfg_d)));
      full_d = 1'b0;
    end
    cnt_d = st_d != st_q ? 7'd0 : cnt_q + 7'd1;
    rdy_d = !full_d;
    busy_d = st_d != IDLE;
    done_d = st_d == STOP_POST && cnt_d == h - 7'd1;
    inj = shd_d[8];
    sl0_d = st_d == BIT_LOW ? sh_d[0] : st_d == PAR ? !par_d ^ inj : st_d != STOP;
    sl1_d = st_d == BIT_LOW ? !sh_d[0] : st_d == PAR ? par_d ^ inj : st_d != STOP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      cfg_q <= 9'h010;
      shd_q <= 9'h010;
      buf_q <= '0;
      sh_q <= '0;
      bits_q <= '0;
      par_q <= 1'b0;
      full_q <= 1'b0;
      rdy_q <= 1'b1;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sl0_q <= 1'b1;
      sl1_q <= 1'b1;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      cfg_q <= cfg_d;
      shd_q <= shd_d;
      buf_q <= buf_d;
      sh_q <= sh_d;
      bits_q <= bits_d;
      par_q <= par_d;
      full_q <= full_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sl0_q <= sl0_d;
      sl1_q <= sl1_d;
    end
  end
endmodule

// File: tb/tb_sl_transmitter.sv
// tb_sl_transmitter: randomized self-checking bench comparing line waveforms against a per-cycle frame model.
module tb_sl_transmitter;
`ifdef SL_TX_PARITY_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, wr_enable = 1'b0, tx_valid = 1'b0;
  logic [15:0] wr_config_w = '0;
  logic [31:0] tx_data_w = '0;
  logic [15:0] r_config_w, status_w;
  logic tx_ready, sl0, sl1, frame_done;
  int n_chk = 0, n_err = 0, cyc = 0, acc_cyc = 0, start_cyc = 0;
  logic rdy0;
  logic [15:0] st0;
  logic [3:0] exp_q[$];

  sl_transmitter dut (
    .clk(clk), .rst(rst), .wr_enable(wr_enable), .wr_config_w(wr_config_w),
    .r_config_w(r_config_w), .tx_data_w(tx_data_w), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .serial_line_zeroes_o(sl0), .serial_line_ones_o(sl1),
    .status_w(status_w), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {frame_done, busy, sl0, sl1} for every cycle of one frame.
  task automatic add_frame(input logic [31:0] w, input int n, input int h, input bit inj);
    int ones = 0;
    for (int i = 0; i < n; i++) begin
      ones += int'(w[i]);
      repeat (h) exp_q.push_back(4'b0111);
      repeat (2 * h) exp_q.push_back(w[i] ? 4'b0110 : 4'b0101);
      repeat (h) exp_q.push_back(4'b0111);
    end
    repeat (h) exp_q.push_back(4'b0111);
    repeat (2 * h) exp_q.push_back({2'b01, 1'b1 ^ 1'((n - ones) % 2) ^ inj, 1'(ones % 2) ^ inj});
    repeat (2 * h) exp_q.push_back(4'b0111);
    repeat (2 * h) exp_q.push_back(4'b0100);
    repeat (h - 1) exp_q.push_back(4'b0111);
    exp_q.push_back(4'b1111);
  endtask

  task automatic cfg_write(input logic [15:0] c);
    wr_enable = 1'b1;
    wr_config_w = c;
    @(posedge clk);
    @(negedge clk);
    wr_enable = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    int t = 0;
    tx_data_w = w;
    tx_valid = 1'b1;
    while (!tx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) check("send timeout", 0, 1);
    else begin
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
    end
    tx_valid = 1'b0;
  endtask

  task automatic watch(input string tag);
    int t = 0;
    while (!status_w[0] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!status_w[0]) begin
      check({tag, " start"}, 0, 1);
      exp_q.delete();
    end else begin
      start_cyc = cyc;
      rdy0 = tx_ready;
      st0 = status_w;
      foreach (exp_q[i]) begin
        check(tag, {frame_done, status_w[0], sl0, sl1}, exp_q[i]);
        @(negedge clk);
      end
      check({tag, " tail"}, {frame_done, status_w[0], sl0, sl1}, 4'b0011);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0] w1, w2;
    logic [15:0] c;
    logic [8:0] exp_cfg;
    int n, rate, nw;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst lines", {sl0, sl1}, 2'b11);
    check("rst ready", tx_ready, 1);
    check("rst cfg", r_config_w, 16'h0010);
    check("rst status", status_w, 16'h0000);
    check("rst done", frame_done, 0);
    rst = 1'b0;
    @(negedge clk);

    cfg_write(16'h000E);
    check("cfg7 rd", r_config_w, 16'h0010);
    check("cfg7 err", status_w[2], 1);
    cfg_write(16'd34 << 1);
    check("cfg34 rd", r_config_w, 16'h0010);
    check("cfg34 err", status_w[2], 1);
    cfg_write(16'd12 << 1);
    check("cfg12 rd", r_config_w, 16'h0018);
    check("cfg12 err", status_w[2], 0);
    exp_cfg = 9'h018;
    for (int i = 0; i < 8; i++) begin
      c = 16'($urandom);
      n = c[5:1] == 0 ? 32 : int'(c[5:1]);
      if (n % 2 == 0 && n >= 8) exp_cfg = c[8:0] & (INJ ? 9'h1FF : 9'h0FF);
      cfg_write(c);
      check("rand cfg rd", r_config_w, {7'b0, exp_cfg});
      check("rand cfg err", status_w[2], !(n % 2 == 0 && n >= 8));
    end

    cfg_write(16'h0010);
    check("cfg10 err", status_w[2], 0);
    send(32'h0000_00A5);
    check("acc ready", tx_ready, 0);
    check("acc status", status_w, 16'h0002);
    add_frame(32'h0000_00A5, 8, 4, 1'b0);
    watch("a5");
    check("latency", start_cyc - acc_cyc, 1);
    check("start ready", rdy0, 1);
    check("start status", st0, 16'h0001);

    cfg_write(16'h0080);
    w2 = $urandom;
    add_frame(32'h1, 32, 16, 1'b0);
    add_frame(w2, 32, 16, 1'b0);
    fork
      begin send(32'h1); send(w2); end
      watch("b2b");
    join

    cfg_write(16'h0010);
    w1 = $urandom;
    w2 = $urandom;
    add_frame(w1, 8, 4, 1'b0);
    add_frame(w2, 16, 4, 1'b0);
    fork
      begin
        send(w1);
        repeat (20) @(negedge clk);
        cfg_write(16'h0020);
        check("midcfg rd", r_config_w, 16'h0020);
        send(w2);
      end
      watch("midcfg");
    join

    for (int it = 0; it < 3; it++) begin
      n = 2 * $urandom_range(4, 16);
      rate = $urandom_range(0, 1);
      c = 16'((rate << 6) | ((n & 31) << 1) | $urandom_range(0, 1));
      cfg_write(c);
      check("rnd cfg", r_config_w, c);
      nw = $urandom_range(1, 2);
      w1 = $urandom;
      w2 = $urandom;
      add_frame(w1, n, 4 << rate, 1'b0);
      if (nw == 2) add_frame(w2, n, 4 << rate, 1'b0);
      fork
        begin send(w1); if (nw == 2) send(w2); end
        watch("rnd");
      join
    end

    cfg_write(16'h0010);
    w1 = $urandom;
    send(w1);
    send($urandom);
    repeat (6) @(negedge clk);
    check("pre-rst bit", {sl0, sl1}, w1[0] ? 2'b10 : 2'b01);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst lines", {sl0, sl1}, 2'b11);
    check("midrst ready", tx_ready, 1);
    check("midrst status", status_w, 16'h0000);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("discard busy", status_w[0], 0);
    check("discard lines", {sl0, sl1}, 2'b11);

    cfg_write(16'h0110);
    check("inj rd", r_config_w, INJ ? 16'h0110 : 16'h0010);
    add_frame(32'h0000_00A5, 8, 4, INJ);
    fork
      send(32'h0000_00A5);
      watch("inj");
    join

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
